// File: rtl/kc_tap_loader.sv
// kc_tap_loader: parses a KC TAP file arriving on the hps_io ioctl download
// bus and writes its program bytes into KC87 main RAM, one byte per write
// handshake, stalling the HPS with ioctl_wait while a write is outstanding.
// Optional feature macro: KC_TAP_AUTOSTART_EN (one-cycle start_req pulse when
// the load completes and the file's start address is not FFFF).
module kc_tap_loader #(
  parameter logic [7:0] TAP_INDEX = 8'd1,
  parameter int         MAGIC_LEN = 16,
  parameter int         BLOCK_LEN = 129
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [15:0] load_addr,
  output logic [15:0] end_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        start_req,
  output logic [15:0] start_addr
);

  // Byte counter limits: last signature byte, payload size and last payload byte
  localparam logic [7:0] MAGIC_LAST   = 8'(MAGIC_LEN - 1);
  localparam logic [7:0] PAYLOAD_LEN  = 8'(BLOCK_LEN - 1);
  localparam logic [7:0] PAYLOAD_LAST = 8'(BLOCK_LEN - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_BLK, S_HDR, S_DATA, S_WR, S_DONE, S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic        active, active_reg, act_rise, act_fall, accept;
  logic        set_done, set_err;
  logic [7:0]  cnt_reg;
  logic [16:0] ptr_reg, ptr_inc, eadr_ext;
  logic [7:0]  wdata_reg;
  logic        hdr_seen_reg, trunc_reg;
  logic [15:0] aadr_reg, eadr_reg, sadr_reg;
  logic [15:0] load_addr_reg, end_addr_reg, start_addr_reg;
  logic        busy_reg, done_reg, error_reg;

  // File signature "\xC3KC-TAPE by AF. "
  function automatic logic [7:0] magic_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    magic_byte = 8'hC3;
      4'd1:    magic_byte = 8'h4B;
      4'd2:    magic_byte = 8'h43;
      4'd3:    magic_byte = 8'h2D;
      4'd4:    magic_byte = 8'h54;
      4'd5:    magic_byte = 8'h41;
      4'd6:    magic_byte = 8'h50;
      4'd7:    magic_byte = 8'h45;
      4'd8:    magic_byte = 8'h20;
      4'd9:    magic_byte = 8'h62;
      4'd10:   magic_byte = 8'h79;
      4'd11:   magic_byte = 8'h20;
      4'd12:   magic_byte = 8'h41;
      4'd13:   magic_byte = 8'h46;
      4'd14:   magic_byte = 8'h2E;
      default: magic_byte = 8'h20;
    endcase
  endfunction

  assign active   = ioctl_download && (ioctl_index == TAP_INDEX);
  assign act_rise = active && !active_reg;
  assign act_fall = !active && active_reg;
  // Strobes seen while stalling are protocol violations and are dropped
  assign accept   = ioctl_wr && !ioctl_wait;
  // Pointer is 17 bits so a load ending at FFFF terminates instead of wrapping
  assign ptr_inc  = ptr_reg + 17'd1;
  assign eadr_ext = {1'b0, end_addr_reg};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic plus the one-cycle done/error set events
  always_comb begin
    state_next = state_reg;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state_reg)
      S_IDLE:  if (act_rise) state_next = S_MAGIC;
      S_MAGIC: begin
        if (act_fall) begin
          set_err = 1'b1; state_next = S_IDLE;
        end else if (accept) begin
          if ((ioctl_data != magic_byte(cnt_reg[3:0])) ||
              ((cnt_reg == 8'd0) && (ioctl_addr != 25'd0))) begin
            set_err = 1'b1; state_next = S_ERR;
          end else if (cnt_reg == MAGIC_LAST) begin
            state_next = S_BLK;
          end
        end
      end
      S_BLK: begin
        if (act_fall) begin
          set_err = 1'b1; state_next = S_IDLE;
        end else if (accept) begin
          state_next = hdr_seen_reg ? S_DATA : S_HDR;
        end
      end
      S_HDR: begin
        if (act_fall) begin
          set_err = 1'b1; state_next = S_IDLE;
        end else if (accept && (cnt_reg == PAYLOAD_LAST)) begin
          if (aadr_reg > eadr_reg) begin
            set_err = 1'b1; state_next = S_ERR;
          end else begin
            state_next = S_BLK;
          end
        end
      end
      S_DATA: begin
        if (act_fall) begin
          set_err = 1'b1; state_next = S_IDLE;
        end else if (accept) begin
          if (ptr_reg <= eadr_ext) begin
            state_next = S_WR;
          end else if (cnt_reg == PAYLOAD_LAST) begin
            set_done   = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_WR: begin
        // The write always finishes; a download that ended meanwhile is judged afterwards
        if (mem_ack) begin
          if (ptr_inc > eadr_ext) begin
            set_done   = 1'b1;
            state_next = (trunc_reg || act_fall) ? S_IDLE : S_DONE;
          end else if (trunc_reg || act_fall) begin
            set_err    = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = (cnt_reg == PAYLOAD_LEN) ? S_BLK : S_DATA;
          end
        end
      end
      S_DONE:  if (act_fall) state_next = S_IDLE;
      S_ERR:   if (act_fall) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs: the RAM request and the HPS stall are both tied to WR
  always_comb begin
    mem_we     = (state_reg == S_WR);
    ioctl_wait = (state_reg == S_WR);
  end

  assign mem_addr   = ptr_reg[15:0];
  assign mem_data   = wdata_reg;
  assign load_addr  = load_addr_reg;
  assign end_addr   = end_addr_reg;
  assign start_addr = start_addr_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

  // Datapath: edge detect, byte counters, header capture, write pointer, status
  always_ff @(posedge clk) begin
    if (reset) begin
      // Track the live level so a download still running after reset is not restarted
      active_reg     <= active;
      cnt_reg        <= 8'd0;
      ptr_reg        <= 17'd0;
      wdata_reg      <= 8'd0;
      hdr_seen_reg   <= 1'b0;
      trunc_reg      <= 1'b0;
      aadr_reg       <= 16'd0;
      eadr_reg       <= 16'd0;
      sadr_reg       <= 16'd0;
      load_addr_reg  <= 16'd0;
      end_addr_reg   <= 16'd0;
      start_addr_reg <= 16'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      active_reg <= active;
      busy_reg   <= state_next inside {S_MAGIC, S_BLK, S_HDR, S_DATA, S_WR};
      if ((state_reg == S_IDLE) && act_rise) begin
        done_reg     <= 1'b0;
        error_reg    <= 1'b0;
        cnt_reg      <= 8'd0;
        hdr_seen_reg <= 1'b0;
        trunc_reg    <= 1'b0;
      end
      if (set_done) done_reg  <= 1'b1;
      if (set_err)  error_reg <= 1'b1;
      case (state_reg)
        S_MAGIC: if (accept) cnt_reg <= cnt_reg + 8'd1;
        S_BLK:   if (accept) cnt_reg <= 8'd0;
        S_HDR: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 8'd1;
            case (cnt_reg)
              8'd17:   aadr_reg[7:0]  <= ioctl_data;
              8'd18:   aadr_reg[15:8] <= ioctl_data;
              8'd19:   eadr_reg[7:0]  <= ioctl_data;
              8'd20:   eadr_reg[15:8] <= ioctl_data;
              8'd21:   sadr_reg[7:0]  <= ioctl_data;
              8'd22:   sadr_reg[15:8] <= ioctl_data;
              default: ;
            endcase
            if (cnt_reg == PAYLOAD_LAST) begin
              hdr_seen_reg   <= 1'b1;
              load_addr_reg  <= aadr_reg;
              end_addr_reg   <= eadr_reg;
              start_addr_reg <= sadr_reg;
              ptr_reg        <= {1'b0, aadr_reg};
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            cnt_reg   <= cnt_reg + 8'd1;
            wdata_reg <= ioctl_data;
          end
        end
        S_WR: begin
          if (act_fall) trunc_reg <= 1'b1;
          if (mem_ack) begin
            ptr_reg   <= ptr_inc;
            trunc_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KC_TAP_AUTOSTART_EN
  logic start_req_reg;

  // Autostart pulse coincides with the rise of done; FFFF means "no autostart"
  always_ff @(posedge clk) begin
    if (reset) start_req_reg <= 1'b0;
    else       start_req_reg <= set_done && (start_addr_reg != 16'hFFFF);
  end

  assign start_req = start_req_reg;
`else
  assign start_req = 1'b0;
`endif

endmodule

// File: tb/tb_kc_tap_loader.sv
// tb_kc_tap_loader: directed and randomized TAP downloads against a
// file-level reference model of which RAM bytes a TAP file must produce.
module tb_kc_tap_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wait, mem_we, mem_ack, busy, done, error, start_req;
  logic [15:0] mem_addr, load_addr, end_addr, start_addr;
  logic [7:0]  mem_data;

  always #5 clk = ~clk;

  kc_tap_loader dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .load_addr(load_addr), .end_addr(end_addr), .busy(busy), .done(done),
    .error(error), .start_req(start_req), .start_addr(start_addr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // RAM arbiter model: acknowledges after ack_delay cycles of mem_we (0 = same cycle)
  int ack_delay = 0;
  int wait_cnt  = 0;
  assign mem_ack = mem_we && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (mem_we && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                    wait_cnt <= 0;
  end

  // Monitor: logs accepted writes and handshake/status anomalies (monotonic counters)
  logic [23:0] wr_q[$];
  int   we_rises = 0, wait_bad = 0, err_cycles = 0, start_cnt = 0, start_bad = 0;
  logic we_prev = 1'b0, ack_prev = 1'b0, done_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_we && mem_ack) wr_q.push_back({mem_addr, mem_data});
    if (mem_we && !we_prev) we_rises <= we_rises + 1;
    if ((ioctl_wait !== mem_we) || (ack_prev && mem_we) ||
        (we_prev && !ack_prev && !mem_we && !reset))
      wait_bad <= wait_bad + 1;
    if (error) err_cycles <= err_cycles + 1;
    if (start_req) start_cnt <= start_cnt + 1;
    if (start_req && !(done && !done_prev)) start_bad <= start_bad + 1;
    we_prev   <= mem_we;
    ack_prev  <= mem_we && mem_ack;
    done_prev <= done;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] sig [16] = '{8'hC3, 8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                           8'h20, 8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20};
  logic [7:0] file_q[$];
  int b_wr, b_rise, b_err, b_start, b_bad, b_sbad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // File offset of program byte i: signature, header block, then 129-byte data blocks
  function automatic int doff(input int i);
    return 16 + 129 + (i / 128) * 129 + 1 + (i % 128);
  endfunction

  task automatic build_file(input logic [15:0] aadr, input logic [15:0] eadr,
                            input logic [15:0] sadr, input int nblk);
    logic [7:0] b;
    file_q.delete();
    for (int k = 0; k < 16; k++) file_q.push_back(sig[k]);
    file_q.push_back(8'h00);
    for (int k = 0; k < 128; k++) begin
      case (k)
        17: b = aadr[7:0];
        18: b = aadr[15:8];
        19: b = eadr[7:0];
        20: b = eadr[15:8];
        21: b = sadr[7:0];
        22: b = sadr[15:8];
        default: b = 8'($urandom);
      endcase
      file_q.push_back(b);
    end
    for (int bl = 1; bl <= nblk; bl++) begin
      file_q.push_back(8'(bl));
      for (int k = 0; k < 128; k++) file_q.push_back(8'($urandom));
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] d, input bit rogue);
    int guard = 0;
    while (ioctl_wait === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_assert++;
      n_fail++;
      $display("FAIL wait_bound byte=%0d ioctl_wait stuck=%0b required=0", idx, ioctl_wait);
    end
    ioctl_addr = 25'(idx);
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
    if (rogue && ioctl_wait === 1'b1) begin
      ioctl_addr = 25'h1FFFFFF;
      ioctl_data = 8'hEE;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input bit rogue);
    for (int i = lo; i <= hi && i < file_q.size(); i++) send_byte(i, file_q[i], rogue);
  endtask

  task automatic start_dl(input logic [7:0] idx, input bit check_clear);
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    if (check_clear) chk("start.clear", {busy, done, error}, 3'b100);
    b_wr = wr_q.size(); b_rise = we_rises; b_err = err_cycles;
    b_start = start_cnt; b_bad = wait_bad; b_sbad = start_bad;
  endtask

  task automatic end_dl();
    int guard = 0;
    while (ioctl_wait === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reference model: which RAM bytes and which final status the file implies
  task automatic check_load(input string tag);
    bit sig_ok, hdr_ok, exp_done;
    int aadr, eadr, sadr, len, nexp, nact, exp_start;
    sig_ok = (file_q.size() >= 16);
    for (int k = 0; k < 16 && k < file_q.size(); k++)
      if (file_q[k] != sig[k]) sig_ok = 1'b0;
    hdr_ok = sig_ok && (file_q.size() >= 16 + 129);
    aadr = 0; eadr = 0; sadr = 0; len = 0; nexp = 0;
    if (hdr_ok) begin
      aadr = {file_q[35], file_q[34]};
      eadr = {file_q[37], file_q[36]};
      sadr = {file_q[39], file_q[38]};
      if (aadr <= eadr) len = eadr - aadr + 1;
    end
    for (int i = 0; i < len; i++) if (doff(i) < file_q.size()) nexp++;
    exp_done = (len > 0) && (nexp == len);
`ifdef KC_TAP_AUTOSTART_EN
    exp_start = (exp_done && sadr != 16'hFFFF) ? 1 : 0;
`else
    exp_start = 0;
`endif
    nact = wr_q.size() - b_wr;
    $display("load %s: aadr=%04h eadr=%04h writes=%0d/%0d done=%0b error=%0b",
             tag, aadr, eadr, nact, nexp, done, error);
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".error"}, error, !exp_done);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".nwrites"}, nact, nexp);
    chk({tag, ".we_rises"}, we_rises - b_rise, nexp);
    chk({tag, ".handshake"}, wait_bad - b_bad, 0);
    chk({tag, ".start_cnt"}, start_cnt - b_start, exp_start);
    chk({tag, ".start_align"}, start_bad - b_sbad, 0);
    if (exp_done) chk({tag, ".err_never"}, err_cycles - b_err, 0);
    if (hdr_ok) begin
      chk({tag, ".load_addr"}, load_addr, aadr);
      chk({tag, ".end_addr"}, end_addr, eadr);
      chk({tag, ".start_addr"}, start_addr, sadr);
    end
    for (int i = 0; i < nexp && i < nact; i++)
      chk($sformatf("%s.wr%0d", tag, i), wr_q[b_wr + i], {16'(aadr + i), file_q[doff(i)]});
  endtask

  task automatic full_load(input string tag, input bit rogue);
    start_dl(8'd1, 1'b1);
    send_range(0, file_q.size() - 1, rogue);
    end_dl();
    check_load(tag);
  endtask

  initial begin
    int nb, aadr_r, len_r;
    logic [15:0] sadr_r;
    void'($urandom(32'd4711));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.flags", {mem_we, ioctl_wait, busy, done, error, start_req}, 6'd0);
    chk("rst.mem", {mem_addr, mem_data}, 24'd0);
    chk("rst.addr", {load_addr, end_addr}, 32'd0);
    chk("rst.sadr", start_addr, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Exactly one data block
    build_file(16'h0300, 16'h037F, 16'h0300, 1);
    full_load("exact128", 1'b0);

    // Short load: the tail of the block is swallowed after done
    build_file(16'h0300, 16'h0305, 16'hFFFF, 1);
    full_load("short6", 1'b0);

    // Corrupt signature byte 5
    build_file(16'h0300, 16'h037F, 16'h0300, 1);
    file_q[5] = 8'h00;
    start_dl(8'd1, 1'b1);
    send_range(0, 4, 1'b0);
    chk("badsig.pre", error, 1'b0);
    send_range(5, 5, 1'b0);
    chk("badsig.post", error, 1'b1);
    send_range(6, file_q.size() - 1, 1'b0);
    end_dl();
    check_load("badsig");

    // Slow RAM with stray strobes during the stall
    ack_delay = 7;
    build_file(16'h1000, 16'h10FF, 16'h1000, 2);
    full_load("slow_ack", 1'b1);
    ack_delay = 0;

    // aadr > eadr
    build_file(16'h0500, 16'h04FF, 16'h0500, 1);
    full_load("order", 1'b0);

    // Load ending at the top of memory
    build_file(16'hFF90, 16'hFFFF, 16'hFF90, 1);
    full_load("top", 1'b0);

    // Truncated file
    build_file(16'h2000, 16'h20FF, 16'h2000, 2);
    repeat (60) void'(file_q.pop_back());
    full_load("trunc", 1'b0);

    // Reset after 40 data bytes; the rest of the stream must be ignored
    build_file(16'h4000, 16'h412B, 16'h4000, 3);
    start_dl(8'd1, 1'b1);
    send_range(0, 185, 1'b0);
    end_dl_wait_only: begin
      int guard = 0;
      while (ioctl_wait === 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid.flags", {mem_we, ioctl_wait, busy, done, error, start_req}, 6'd0);
    chk("rstmid.mem", {mem_addr, mem_data}, 24'd0);
    chk("rstmid.addr", {load_addr, end_addr}, 32'd0);
    chk("rstmid.sadr", start_addr, 16'd0);
    nb = wr_q.size();
    chk("rstmid.nwrites", nb - b_wr, 40);
    chk("rstmid.last", wr_q[nb - 1], {16'h4027, file_q[185]});
    send_range(186, file_q.size() - 1, 1'b0);
    end_dl();
    $display("load rstmid: writes after reset=%0d busy=%0b", wr_q.size() - nb, busy);
    chk("rstmid.after", wr_q.size() - nb, 0);
    chk("rstmid.idle", {busy, done, error}, 3'b000);

    // Download for another target index is not ours
    build_file(16'h0300, 16'h037F, 16'h0300, 1);
    start_dl(8'd2, 1'b0);
    send_range(0, file_q.size() - 1, 1'b0);
    end_dl();
    $display("load other_index: writes=%0d", wr_q.size() - b_wr);
    chk("idx.nwrites", wr_q.size() - b_wr, 0);
    chk("idx.busy", busy, 1'b0);

    // Randomized files and RAM latencies
    for (int t = 0; t < 5; t++) begin
      aadr_r = $urandom_range(0, 16'hFFFF);
      len_r  = $urandom_range(1, 300);
      if (aadr_r + len_r > 32'h10000) len_r = 32'h10000 - aadr_r;
      sadr_r = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'(aadr_r);
      ack_delay = $urandom_range(0, 3);
      build_file(16'(aadr_r), 16'(aadr_r + len_r - 1), sadr_r, (len_r + 127) / 128);
      full_load($sformatf("rand%0d", t), 1'b0);
    end
    ack_delay = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
